// File: rtl/ifetch_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch_pkg
// Description : Shared constants and types for the instruction prefetch unit:
//               PC increment, canonical NOP encoding and the per-cycle
//               consume decision taken on the core PC.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_prefetch_pkg;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_INC = 4;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] NOP = 32'h0000_0013;

    // What the prefetcher does with the FIFO given the core PC this cycle.
    typedef enum logic [1:0] {
        CONSUME_HOLD     = 2'd0,  // core still wants the head instruction
        CONSUME_ADVANCE  = 2'd1,  // core moved on sequentially, retire head
        CONSUME_REDIRECT = 2'd2   // discontinuity, restart fetch at core PC
    } consume_e;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Small synchronous FIFO holding prefetched instruction words.
//               Exposes the head entry and the entry behind it so the core can
//               be served without a bubble while the head is being retired.
// Ports       : clk_i    - clock
//               rst_ni   - synchronous active-low reset
//               flush_i  - discard all entries (wins over push/pop)
//               push_i   - write data_i at the tail
//               data_i   - word to push
//               pop_i    - retire the head entry
//               head_o   - head entry
//               next_o   - entry behind the head
//               count_o  - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] next_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_inc;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is cleared on reset so the instruction output reads zero
    // out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i[PTR_W-1:0]] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_inc];
    assign count_o = count_q;

    // The issue credit upstream guarantees a free slot for every response.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch
// Description : Instruction prefetch unit between the core fetch port and a
//               pipelined in-order instruction bus. Fetches sequential words
//               ahead of the core into a FIFO, serves the core from the FIFO
//               head (or the entry behind it), and on a PC discontinuity
//               flushes the FIFO and discards responses already in flight.
// Ports       : i_clk        - clock
//               i_rst_n      - synchronous active-low reset
//               i_pc         - core fetch PC
//               o_instr      - instruction for i_pc
//               o_ifValid    - o_instr is valid for i_pc this cycle
//               o_memReq     - bus request valid
//               o_memAddr    - bus word address
//               i_memGnt     - request accepted this cycle
//               i_memRvalid  - response valid (in request order)
//               i_memRdata   - response data
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     INSTR_WIDTH     = 32,
    parameter logic [XLEN-1:0] PC_START        = '0,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [XLEN-1:0]        i_pc,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_ifValid,
    output logic                   o_memReq,
    output logic [XLEN-1:0]        o_memAddr,
    input  logic                   i_memGnt,
    input  logic                   i_memRvalid,
    input  logic [INSTR_WIDTH-1:0] i_memRdata
);

    localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned     INF_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned     CRD_W   = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

    logic [XLEN-1:0]        head_pc_q, head_pc_d;
    logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
    logic [INF_W-1:0]       inflight_q, inflight_d;
    logic [INF_W-1:0]       drop_q, drop_d;

    logic [XLEN-1:0]        head_pc_plus;
    consume_e               consume;
    logic [CNT_W-1:0]       fifo_count;
    logic [INSTR_WIDTH-1:0] fifo_head;
    logic [INSTR_WIDTH-1:0] fifo_next;
    logic [CRD_W-1:0]       credit_used;
    logic                   req;
    logic                   fire;
    logic                   rsp_stale;
    logic                   push;
    logic                   pop;
    logic                   flush;

    // ------------------------------------------------------------------
    // Consume decision from the core PC
    // ------------------------------------------------------------------
    always_comb begin
        head_pc_plus = head_pc_q + PC_STEP;
        consume      = CONSUME_REDIRECT;
        if (i_pc == head_pc_q) begin
            consume = CONSUME_HOLD;
        end else if ((i_pc == head_pc_plus) && (fifo_count != '0)) begin
            consume = CONSUME_ADVANCE;
        end
    end

    // ------------------------------------------------------------------
    // Issue: entries held + live (non-stale) requests may not exceed the
    // FIFO size, so every accepted response is guaranteed a slot. The
    // request is held low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        credit_used = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(drop_q);
        req         = i_rst_n
                   && (consume != CONSUME_REDIRECT)
                   && (inflight_q < INF_W'(MAX_OUTSTANDING))
                   && (credit_used < CRD_W'(DEPTH));
        fire        = req && i_memGnt;
    end

    assign o_memReq  = req;
    assign o_memAddr = fetch_pc_q;

    // ------------------------------------------------------------------
    // Response handling and FIFO control. A live response landing on a
    // redirect cycle is simply lost: the FIFO is being cleared anyway.
    // ------------------------------------------------------------------
    always_comb begin
        rsp_stale = i_memRvalid && (drop_q != '0);
        push      = i_memRvalid && (drop_q == '0) && (consume != CONSUME_REDIRECT);
        pop       = (consume == CONSUME_ADVANCE);
        flush     = (consume == CONSUME_REDIRECT);
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d = inflight_q + INF_W'(fire) - INF_W'(i_memRvalid);
        drop_d     = drop_q - INF_W'(rsp_stale);
        head_pc_d  = head_pc_q;
        fetch_pc_d = fire ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
        unique case (consume)
            CONSUME_HOLD: begin
                head_pc_d = head_pc_q;
            end
            CONSUME_ADVANCE: begin
                head_pc_d = head_pc_plus;
            end
            CONSUME_REDIRECT: begin
                head_pc_d  = i_pc;
                fetch_pc_d = i_pc;
                // Everything still outstanding after this cycle belongs to
                // the old stream; any response this cycle is already counted
                // out of inflight_d.
                drop_d     = inflight_d;
            end
            default: begin
                head_pc_d = head_pc_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_pc_q  <= PC_START;
            fetch_pc_q <= PC_START;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            head_pc_q  <= head_pc_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    ifetch_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (i_memRdata),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .count_o (fifo_count)
    );

    // ------------------------------------------------------------------
    // Output select: serve the head, or the entry behind it when the core
    // has already moved one word past the head (the advance cycle).
    // ------------------------------------------------------------------
    always_comb begin
        o_instr   = fifo_head;
        o_ifValid = 1'b0;
        if ((i_pc == head_pc_q) && (fifo_count != '0)) begin
            o_ifValid = 1'b1;
        end else if ((i_pc == head_pc_plus) && (fifo_count > CNT_W'(1))) begin
            o_instr   = fifo_next;
            o_ifValid = 1'b1;
        end
    end

    a_drop_le_inflight : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        drop_q <= inflight_q);

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_prefetch
// Description : Self-checking bench for ifetch_prefetch. A behavioural bus
//               returns mem_of(addr) in request order after a configurable
//               latency; a simple core model follows o_ifValid. Every valid
//               instruction must equal mem_of(i_pc).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IW       = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAXO     = 4;
    localparam logic [31:0] PC_START = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pc = PC_START;
    logic [31:0]   instr;
    logic          if_valid;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          gnt = 1'b1;
    logic          rvalid = 1'b0;
    logic [31:0]   rdata = '0;

    always #5 clk = ~clk;

    ifetch_prefetch #(
        .XLEN            (XLEN),
        .INSTR_WIDTH     (IW),
        .PC_START        (PC_START),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pc        (pc),
        .o_instr     (instr),
        .o_ifValid   (if_valid),
        .o_memReq    (mem_req),
        .o_memAddr   (mem_addr),
        .i_memGnt    (gnt),
        .i_memRvalid (rvalid),
        .i_memRdata  (rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Instruction memory contents: a bijection of the address.
    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0DE_0013;
    endfunction

    // ---------------- behavioural in-order bus ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_req_t;

    bus_req_t    bq[$];
    logic [31:0] fired[$];
    int          bcyc     = 0;
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;

    // Accept requests mid-cycle; a request accepted in cycle c returns no
    // earlier than cycle c+lat, one response per cycle, in order.
    always @(negedge clk) begin
        bus_req_t e;
        int       due;
        if (!rst_n) begin
            bq.delete();
            last_due = 0;
        end else if (mem_req && gnt) begin
            due = bcyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            e.addr   = mem_addr;
            e.due    = due;
            bq.push_back(e);
            fired.push_back(mem_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        bcyc++;
        if (bq.size() > 0 && bq[0].due <= bcyc) begin
            rvalid = 1'b1;
            rdata  = mem_of(bq[0].addr);
            void'(bq.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
    end

    // ---------------- core model helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One core cycle: sample, check data, then move the PC forward only if
    // the instruction was delivered (unless told to hold).
    task automatic core_cycle(input string tag, input bit hold, output bit was_valid);
        @(negedge clk);
        was_valid = if_valid;
        if (if_valid) check({tag, "_instr"}, instr, mem_of(pc));
        tick();
        if (was_valid && !hold) pc = pc + 32'd4;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pc    = PC_START;
        gnt   = 1'b1;
        repeat (3) tick();
        fired.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1);
    end

    initial begin
        bit          v;
        bit          got;
        int          first;
        int          idle;
        int          retired;
        int          nbad;
        logic [31:0] a0;

        // ---------------- reset state ----------------
        apply_reset();
        @(negedge clk);
        check("rst_memReq", mem_req, 0);
        check("rst_ifValid", if_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_memAddr", mem_addr, PC_START);
        tick();
        rst_n = 1'b1;

        // ---------------- 1: straight-line streaming ----------------
        // Cycle 0 issues addr 0, the response lands in cycle 1, and the
        // instruction is valid from cycle 2 on with no bubbles.
        first = -1;
        for (int c = 0; c < 16; c++) begin
            core_cycle("t1", 1'b0, v);
            if (c >= 2) check("t1_nobubble", v, 1);
            if (v && first < 0) first = c;
        end
        check("t1_first_valid", first, 2);
        check("t1_req_count", fired.size() >= 4, 1);
        if (fired.size() >= 4)
            for (int k = 0; k < 4; k++) check("t1_req_order", fired[k], k * 4);

        // ---------------- 2: core holds PC=8 ----------------
        fired.delete();
        pc = 32'h8;
        repeat (9) core_cycle("t2", 1'b1, v);
        @(negedge clk);
        check("t2_req_stopped", mem_req, 0);
        check("t2_valid", if_valid, 1);
        check("t2_instr", instr, mem_of(32'h8));
        check("t2_fired", fired.size(), DEPTH);
        for (int k = 0; k < fired.size() && k < DEPTH; k++)
            check("t2_fired_addr", fired[k], 32'h8 + k * 4);
        tick();
        for (int k = 0; k < 8; k++) begin
            core_cycle("t2r", 1'b0, v);
            check("t2r_nobubble", v, 1);
        end
        check("t2_resumed", fired.size() > DEPTH, 1);

        // ---------------- 3: redirect with 3 requests in flight ----------
        lat_min = 5;
        lat_max = 5;
        pc = 32'h10;
        repeat (4) core_cycle("t3a", 1'b1, v);
        pc = 32'h100;
        @(negedge clk);
        check("t3_noreq_on_redirect", mem_req, 0);
        check("t3_novalid_on_redirect", if_valid, 0);
        tick();
        @(negedge clk);
        check("t3_req_after", mem_req, 1);
        check("t3_addr_after", mem_addr, 32'h100);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            core_cycle("t3", 1'b1, v);
            got = v;
        end
        check("t3_valid_seen", got, 1);

        // ---------------- 4: grant stall ----------------
        lat_min = 1;
        lat_max = 1;
        pc = 32'h200;
        repeat (10) core_cycle("t4a", 1'b0, v);
        gnt  = 1'b0;
        nbad = 0;
        a0   = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) a0 = mem_addr;
            check("t4_req_held", mem_req, 1);
            check("t4_addr_stable", mem_addr, a0);
            v = if_valid;
            if (v) check("t4_instr", instr, mem_of(pc));
            else nbad++;
            tick();
            if (v) pc = pc + 32'd4;
        end
        check("t4_drained", nbad > 0, 1);
        gnt = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            core_cycle("t4r", 1'b0, v);
            got = v;
        end
        check("t4_recovered", got, 1);
        repeat (6) core_cycle("t4s", 1'b0, v);

        // ---------------- 5: random latency, grants, redirects ----------
        lat_min = 1;
        lat_max = 6;
        idle    = 0;
        retired = 0;
        for (int k = 0; k < 1500; k++) begin
            gnt = ($urandom_range(9, 0) < 7);
            @(negedge clk);
            v = if_valid;
            if (v) begin
                check("t5_instr", instr, mem_of(pc));
                retired++;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle >= 80) begin
                check("t5_stall", idle, 0);
                idle = 0;
            end
            tick();
            if ((v && $urandom_range(7, 0) == 0) || (!v && $urandom_range(31, 0) == 0)) begin
                if ($urandom_range(3, 0) == 0)
                    pc = 32'hFFFF_FFE0 + 32'($urandom_range(7, 0)) * 32'd4;
                else
                    pc = 32'($urandom_range(1023, 0)) * 32'd4;
            end else if (v) begin
                pc = pc + 32'd4;
            end
        end
        check("t5_progress", retired > 200, 1);

        // ---------------- 6: reset mid-operation ----------------
        gnt     = 1'b1;
        lat_min = 3;
        lat_max = 3;
        pc = 32'h300;
        repeat (6) core_cycle("t6a", 1'b1, v);
        rst_n = 1'b0;
        pc    = PC_START;
        tick();
        @(negedge clk);
        check("t6_rst_memReq", mem_req, 0);
        check("t6_rst_ifValid", if_valid, 0);
        check("t6_rst_memAddr", mem_addr, PC_START);
        check("t6_rst_instr", instr, 0);
        lat_min = 1;
        lat_max = 1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rel_memReq", mem_req, 1);
        check("t6_rel_memAddr", mem_addr, PC_START);
        check("t6_rel_ifValid", if_valid, 0);
        first = -1;
        for (int c = 0; c < 8; c++) begin
            core_cycle("t6", 1'b0, v);
            if (v && first < 0) first = c;
        end
        // Sampling of cycle 0 above was taken outside core_cycle, so the
        // first valid cycle (absolute cycle 2) shows up here as index 1.
        check("t6_first_valid", first, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
